mole_round_ctrl: RTL and testbench

Round sequencer for the 4-key reaction game. Pulses the random key generator for a new target, lights the matching LED, and waits for the player's key press or a timeout. It scores each round as hit or miss and ends the game after a fixed number of rounds. It sits between the debounced key inputs, the random key generator (`en_random`/`key_random`) and the LED/score display logic.

---
 rtl/mole_pkg.sv | 13 +
 rtl/key_edge_det.sv | 21 ++
 rtl/mole_round_ctrl.sv | 109 ++++++++++
 tb/tb_mole_round_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared states, constants and helpers for the reaction-game round sequencer
package mole_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_LATCH, S_SHOW, S_GAP, S_DONE} state_t;
    localparam int KEYS = 4;
    localparam int LVL_MAX = 3;
    localparam int HITS_PER_LVL = 4;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
    function automatic logic [1:0] lvl_of(input logic [7:0] s);
        return (s >= 8'(HITS_PER_LVL * LVL_MAX)) ? 2'(LVL_MAX) : 2'(s / 8'(HITS_PER_LVL));
    endfunction
endpackage

// File: rtl/key_edge_det.sv
// key_edge_det: registers the key inputs and flags 0->1 transitions one cycle later
module key_edge_det import mole_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KEYS-1:0] key_in,
    output logic [KEYS-1:0] rise,
    output logic [KEYS-1:0] key_lvl
);
    logic [KEYS-1:0] key_q;
    // two-stage key history, kept in every state so held keys never look like presses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_lvl <= '0;
            key_q   <= '0;
        end else begin
            key_lvl <= key_in;
            key_q   <= key_lvl;
        end
    end
    assign rise = key_lvl & ~key_q;
endmodule

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: round sequencer for the 4-key reaction game (optional MOLE_LEVEL_EN difficulty levels)
module mole_round_ctrl import mole_pkg::*; #(
    parameter int ROUNDS  = 16,
    parameter int TIMEOUT = 4000000,
    parameter int GAP     = 1000000,
    parameter int TO_W    = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KEYS-1:0] key_in,
    input  logic [KEYS-1:0] key_random,
    output logic            en_random,
    output logic [KEYS-1:0] led,
    output logic [7:0]      score,
    output logic [7:0]      miss_cnt,
    output logic [7:0]      round,
    output logic [1:0]      level,
    output logic            busy,
    output logic            done
);
    state_t          state, state_nx;
    logic [TO_W-1:0] cnt, window;
    logic [KEYS-1:0] target, rise, key_lvl;
    logic            press, hit, expire, restart, unused_ok;

    key_edge_det u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_in  (key_in),
        .rise    (rise),
        .key_lvl (key_lvl)
    );

    assign unused_ok = ^key_random[3:2];
    assign press     = (state == S_SHOW) && |rise;
    assign hit       = press && (key_lvl == target);
    assign expire    = cnt == TO_W'(1);
    assign restart   = start && (state == S_IDLE || state == S_DONE);

`ifdef MOLE_LEVEL_EN
    // level follows the hit count; the window picks it up at the next LATCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level <= 2'd0;
        else if (restart) level <= 2'd0;
        else if (hit) level <= lvl_of(sat_inc(score));
    end
    assign window = TO_W'(TIMEOUT) >> level;
`else
    assign level  = 2'd0;
    assign window = TO_W'(TIMEOUT);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end

    // next-state and state-decoded outputs
    always_comb begin
        state_nx  = state;
        en_random = state == S_DRAW;
        led       = (state == S_SHOW) ? target : '0;
        busy      = state inside {S_DRAW, S_LATCH, S_SHOW, S_GAP};
        done      = state == S_DONE;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_DRAW;
            S_DRAW:         state_nx = S_LATCH;
            S_LATCH:        state_nx = S_SHOW;
            S_SHOW:         if (press || expire) state_nx = S_GAP;
            S_GAP:          if (expire) state_nx = (round == 8'(ROUNDS)) ? S_DONE : S_DRAW;
            default:        state_nx = S_IDLE;
        endcase
    end

    // target latch, window/gap counter and saturating score counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            target   <= '0;
            score    <= '0;
            miss_cnt <= '0;
            round    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    score    <= '0;
                    miss_cnt <= '0;
                    round    <= '0;
                end
                S_LATCH: begin
                    target <= KEYS'(1) << key_random[1:0];
                    cnt    <= window;
                end
                S_SHOW: if (press || expire) begin
                    score    <= hit ? sat_inc(score) : score;
                    miss_cnt <= hit ? miss_cnt : sat_inc(miss_cnt);
                    round    <= round + 8'd1;
                    cnt      <= TO_W'(GAP);
                end else begin
                    cnt <= cnt - TO_W'(1);
                end
                S_GAP:   cnt <= cnt - TO_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: randomized scoreboard bench for mole_round_ctrl against a round-level game model
module tb_mole_round_ctrl;
`ifdef MOLE_LEVEL_EN
    localparam int ROUNDS = 8;
    localparam bit LVL_EN = 1'b1;
    localparam int PLAN1_T [8] = '{1, 1, 1, 1, 0, 4, 2, 1};
    localparam int PLAN1_J [8] = '{5, 2, 19, 3, 0, 0, 0, 0};
`else
    localparam int ROUNDS = 4;
    localparam bit LVL_EN = 1'b0;
    localparam int PLAN1_T [4] = '{1, 2, 0, 3};
    localparam int PLAN1_J [4] = '{5, 0, 0, 0};
`endif
    localparam int TIMEOUT = 20;
    localparam int GAP = 4;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] key_in = 4'd0, key_random = 4'd0;
    logic       en_random, busy, done;
    logic [3:0] led;
    logic [7:0] score, miss_cnt, round;
    logic [1:0] level;

    typedef struct {
        logic [3:0] target;
        int         dur;
        int         score;
        int         miss;
        int         round;
        int         level;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0;
    int         m_score, m_miss, m_round, last_wait;
    int         mon_len;
    logic [3:0] mon_last;

    mole_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT), .GAP(GAP), .TO_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .key_random (key_random),
        .en_random  (en_random),
        .led        (led),
        .score      (score),
        .miss_cnt   (miss_cnt),
        .round      (round),
        .level      (level),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic int m_level();
        return LVL_EN ? ((m_score / 4 > 3) ? 3 : m_score / 4) : 0;
    endfunction

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : v;
    endfunction

    task automatic model_clear();
        m_score = 0;
        m_miss  = 0;
        m_round = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // typ: 0 none, 1 correct key, 2 wrong key, 3 held through SHOW, 4 held then release and re-press
    task automatic play_round(input int typ, input int jfix, input bit pulse);
        int         w, jp, dur, waited;
        bit         det;
        logic [3:0] kr, tgt, v;
        exp_t       e;
        waited = 0;
        while (!en_random && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        if (!en_random) begin
            checks++;
            errors++;
            $display("FAIL draw_wait: en_random not seen after %0d cycles", waited);
            return;
        end
        kr  = 4'($urandom);
        tgt = 4'b0001 << kr[1:0];
        w   = TIMEOUT >> m_level();
        v   = tgt;
        jp  = 0;
        case ($urandom_range(0, 3))
            0: jp = 1;
            1: jp = w - 1;
            2: jp = w;
            default: jp = $urandom_range(1, w);
        endcase
        if (jfix != 0) jp = jfix;
        if (typ == 0 || typ == 3) jp = 0;
        if (typ == 2) do v = 4'($urandom_range(1, 15)); while (v == tgt);
        if (typ == 4) jp = (w >= 5) ? $urandom_range(4, w) : 0;
        if (typ == 3 || typ == 4) key_in = tgt;
        det = (jp != 0) && (jp + 1 <= w);
        dur = det ? jp + 1 : w;
        if (det && v == tgt) m_score = sat(m_score);
        else m_miss = sat(m_miss);
        m_round++;
        e.target = tgt;
        e.dur    = dur;
        e.score  = m_score;
        e.miss   = m_miss;
        e.round  = m_round;
        e.level  = m_level();
        q.push_back(e);
        @(posedge clk);
        #1 key_random = kr;
        @(negedge clk);
        check("en_random_one_cycle", en_random, 0);
        check("busy_latch", busy, 1);
        for (int j = 1; j <= dur; j++) begin
            @(negedge clk);
            if (j == 1) check("led_first_show", led, tgt);
            start = pulse && j == 2;
            if (typ == 4 && j == 2) key_in = 4'd0;
            if (j == jp) key_in = v;
        end
        @(negedge clk);
        key_in = 4'd0;
        start  = 1'b0;
    endtask

    task automatic end_of_game();
        repeat (GAP + 2) @(negedge clk);
        check("done_set", done, 1);
        check("round_final", round, ROUNDS);
        check("busy_done", busy, 0);
        check("led_done", led, 0);
        repeat (5) @(negedge clk);
        check("score_hold", score, m_score);
        check("miss_hold", miss_cnt, m_miss);
        check("done_hold", {done, en_random}, 2'b10);
    endtask

    // monitor: a SHOW interval ending (led falling to 0) retires one scoreboard entry
    initial begin
        mon_len  = 0;
        mon_last = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_len  = 0;
                mon_last = 4'd0;
            end else if (led != 4'd0) begin
                mon_len++;
                mon_last = led;
            end else if (mon_last != 4'd0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL round_end: got unexpected round end, want none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("target", mon_last, e.target);
                    check("show_len", mon_len, e.dur);
                    check("score", score, e.score);
                    check("miss_cnt", miss_cnt, e.miss);
                    check("round", round, e.round);
                    check("level", level, e.level);
                end
                mon_len  = 0;
                mon_last = 4'd0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_outputs", {led, score, miss_cnt, round, level, en_random, busy, done}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {busy, done, en_random, led}, 0);
        pulse_start();
        for (int r = 0; r < ROUNDS; r++) begin
            play_round(PLAN1_T[r], PLAN1_J[r], r == 1);
            if (r == 0) check("start_to_draw", last_wait, 0);
        end
        end_of_game();
        model_clear();
        pulse_start();
        for (int r = 0; r < ROUNDS; r++) play_round($urandom_range(0, 4), 0, 1'($urandom));
        end_of_game();
        model_clear();
        pulse_start();
        play_round(1, 3, 0);
        for (int k = 0; k < 200 && !en_random; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("busy_pre_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_show", {led, score, miss_cnt, round, level, en_random, busy, done}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done, led}, 0);
        model_clear();
        pulse_start();
        play_round(2, 0, 0);
        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
